sha3_scan_dispatcher: RTL and testbench
=======================================

// Module: sha3_scan_dispatcher
// PURPOSE
// - Job-side driver for sha3_scanner_instantiator: accepts a work item, drives start/blobby/threshold.
// - Slides the nonce window across up to job_slices scanner runs; returns one result per job.
// - Sits between the host/AXI register front-end and the scanner instantiator; same clk domain.
// PARAMETERS
// - INPUT_ELEMENTS  20  words in blobby; 20 = PROPER, 24 = legacy
// - NONCE_WORD      19  blobby word index holding the first nonce of a run; < INPUT_ELEMENTS
// PORTS
// - clk              in   1      sole clock; also drives the instantiator
// - rst              in   1      reset, asynchronous, active-low
// - job_valid        in   1      job offered
// - job_ready        out  1      dispatcher can take a job (state IDLE)
// - job_blobby       in   32xIE  header words; NONCE_WORD = first nonce
// - job_threshold    in   64     difficulty threshold
// - job_slices       in   16     scanner runs allowed; 0 treated as 1
// - abort            in   1      give up the current job at the next run boundary
// - sc_start         out  1      start strobe to scanner
// - sc_blobby        out  32xIE  held stable from ISSUE until the run ends
// - sc_threshold     out  64     latched job threshold
// - sc_idle          in   1      scanner idle
// - sc_found         in   1      scanner result valid; sticky until the next start
// - sc_hash          in   64x25  scanner hash
// - sc_nonce         in   32     scanner nonce
// - sc_evaluating    in   1      one hash tested this cycle
// - sc_scan_count    in   32     nonces per run; constant
// - res_valid        out  1      result available
// - res_ready        in   1      result consumed
// - res_found        out  1      1 = hash/nonce valid; 0 = exhausted or aborted
// - res_aborted      out  1      job ended by abort
// - res_hash         out  64x25  captured hash
// - res_nonce        out  32     captured nonce
// - res_runs         out  16     scanner runs issued for this job
// - res_hashes       out  64     sc_evaluating cycles counted during the job
// BEHAVIOUR
// - Reset: state IDLE, job_ready=1, all other outputs and registers 0.
// - FSM states: IDLE, ISSUE, ACK, RUN, DECIDE, REPORT.
// - IDLE: on job_valid&job_ready, latch blobby/threshold/slices (0->1) and go to ISSUE.
//   The accept edge clears runs, hashes and the abort flag.
// - ISSUE: wait for sc_idle=1, then sc_start=1 for exactly 1 cycle and go to ACK.
// - ACK: wait for sc_idle=0, then go to RUN. sc_start stays 0 throughout ACK.
// - RUN: wait for sc_idle=1 (run complete), then go to DECIDE. runs increments on the ISSUE->ACK edge.
// - DECIDE, evaluated in this priority order:
//   1. sc_found: capture hash/nonce, res_found=1, go to REPORT.
//   2. abort flag set: res_found=0, res_aborted=1, go to REPORT.
//   3. runs==slices: res_found=0, go to REPORT.
//   4. Otherwise: nonce word += sc_scan_count (32-bit).
//      If the add carries out, the job is exhausted: res_found=0, go to REPORT.
//      If not, go to ISSUE.
// - REPORT: res_valid=1 and res_* held stable until res_ready. Then go to IDLE; res_valid drops next cycle.
// - abort is sampled in any non-IDLE state and sets a sticky flag. It never cuts a run short.
// - abort asserted in IDLE or in REPORT is ignored.
// - hashes += sc_evaluating every cycle in ACK, RUN or DECIDE; saturates at 2^64-1.
// - Result latency: found run -> res_valid 2 cycles after sc_idle rises (DECIDE, then REPORT).
// - sc_threshold/sc_blobby change only in IDLE (accept) or DECIDE (nonce advance), never while sc_idle=0.
// - Reset asserted mid-job: return to IDLE immediately. The scanner is not aborted.
//   ISSUE waits for sc_idle before starting a new run.
// STRUCTURE
// - Package sha3_scan_pkg holds:
//   - typedef dispatch_state_e (FSM states)
//   - typedef scan_result_t (found, aborted, hash[25], nonce, runs, hashes)
//   - localparams for the PROPER/legacy INPUT_ELEMENTS values (20/24)
// - No sub-module. FSM, job registers and counters live in a single always_ff block with async reset.
// TESTING
// - Single-run hit: slices=1, model sets sc_found with nonce=0x1234 on run end
//   -> res_valid, res_found=1, res_nonce=0x1234, res_runs=1.
// - Multi-run miss: slices=3, scan_count=0x100, first nonce 0x10, no hit
//   -> 3 sc_start pulses with nonce words 0x10, 0x110, 0x210; res_found=0, res_runs=3.
// - Wrap: first nonce 0xFFFFFF80, scan_count=0x100, slices=5, no hit
//   -> res_found=0 and res_runs=1 (carry out ends the job).
// - Abort: abort pulsed mid-run 2 of 4, no hit -> run 2 completes; res_aborted=1, res_runs=2.
// - Backpressure: res_ready held 0 for 10 cycles -> res_* stable, job_ready=0;
//   next job accepted only after the handshake.
// - Async reset during RUN -> outputs return to reset values at once;
//   the next job's sc_start is delayed until sc_idle=1.

Source files
------------

// File: rtl/sha3_scan_dispatcher_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sha3_scan_pkg
//  Description : Shared types and constants for the SHA3 scan dispatcher:
//                FSM state encoding, per-job result record and the two
//                supported blobby lengths.
//  Revision    : 1.0 - initial release
// ============================================================================
package sha3_scan_pkg;

    // Blobby lengths understood by the scanner instantiator
    localparam int C_INPUT_ELEMENTS_PROPER = 20;
    localparam int C_INPUT_ELEMENTS_LEGACY = 24;

    // Keccak state is 25 lanes of 64 bits
    localparam int C_HASH_WORDS = 25;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_ACK    = 3'd2,
        ST_RUN    = 3'd3,
        ST_DECIDE = 3'd4,
        ST_REPORT = 3'd5
    } dispatch_state_e;

    typedef struct packed {
        logic                          found;
        logic                          aborted;
        logic [C_HASH_WORDS-1:0][63:0] hash;
        logic [31:0]                   nonce;
        logic [15:0]                   runs;
        logic [63:0]                   hashes;
    } scan_result_t;

endpackage
`default_nettype wire

// File: rtl/sha3_scan_dispatcher_if.sv
`default_nettype none
// ============================================================================
//  Module      : sha3_scan_dispatcher_if
//  Description : Job, scanner and result signals of the SHA3 scan dispatcher.
//                master = the dispatcher, slave = host front-end plus scanner.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sha3_scan_dispatcher_if
    import sha3_scan_pkg::*;
#(
    parameter int INPUT_ELEMENTS = C_INPUT_ELEMENTS_PROPER
);
    // Job side
    logic                              job_valid;
    logic                              job_ready;
    logic [INPUT_ELEMENTS-1:0][31:0]   job_blobby;
    logic [63:0]                       job_threshold;
    logic [15:0]                       job_slices;
    logic                              abort;

    // Scanner side
    logic                              sc_start;
    logic [INPUT_ELEMENTS-1:0][31:0]   sc_blobby;
    logic [63:0]                       sc_threshold;
    logic                              sc_idle;
    logic                              sc_found;
    logic [C_HASH_WORDS-1:0][63:0]     sc_hash;
    logic [31:0]                       sc_nonce;
    logic                              sc_evaluating;
    logic [31:0]                       sc_scan_count;

    // Result side
    logic                              res_valid;
    logic                              res_ready;
    logic                              res_found;
    logic                              res_aborted;
    logic [C_HASH_WORDS-1:0][63:0]     res_hash;
    logic [31:0]                       res_nonce;
    logic [15:0]                       res_runs;
    logic [63:0]                       res_hashes;

    modport master (
        input  job_valid, job_blobby, job_threshold, job_slices, abort,
               sc_idle, sc_found, sc_hash, sc_nonce, sc_evaluating, sc_scan_count,
               res_ready,
        output job_ready, sc_start, sc_blobby, sc_threshold,
               res_valid, res_found, res_aborted, res_hash, res_nonce, res_runs, res_hashes
    );

    modport slave (
        output job_valid, job_blobby, job_threshold, job_slices, abort,
               sc_idle, sc_found, sc_hash, sc_nonce, sc_evaluating, sc_scan_count,
               res_ready,
        input  job_ready, sc_start, sc_blobby, sc_threshold,
               res_valid, res_found, res_aborted, res_hash, res_nonce, res_runs, res_hashes
    );

endinterface
`default_nettype wire

// File: rtl/sha3_scan_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module      : sha3_scan_dispatcher
//  Description : Takes one work item, slides the nonce window over up to
//                job_slices scanner runs and returns one result per job.
//  Revision    : 1.0 - initial release
// ============================================================================
module sha3_scan_dispatcher
    import sha3_scan_pkg::*;
#(
    parameter int INPUT_ELEMENTS = C_INPUT_ELEMENTS_PROPER,
    parameter int NONCE_WORD     = 19
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    sha3_scan_dispatcher_if.master bus
);

    dispatch_state_e                 r_state;
    dispatch_state_e                 w_next_state;
    logic [INPUT_ELEMENTS-1:0][31:0] r_blobby;
    logic [63:0]                     r_threshold;
    logic [15:0]                     r_slices;
    logic                            r_abort;
    scan_result_t                    r_result;

    logic                            w_start;
    logic [32:0]                     w_nonce_sum;
    logic                            w_runs_done;
    logic                            w_counting;
    logic                            w_abort_window;

    // Next window start; bit 32 is the carry that marks nonce-space exhaustion
    assign w_nonce_sum    = {1'b0, r_blobby[NONCE_WORD]} + {1'b0, bus.sc_scan_count};
    assign w_runs_done    = (r_result.runs == r_slices);
    assign w_counting     = (r_state == ST_ACK) || (r_state == ST_RUN) || (r_state == ST_DECIDE);
    assign w_abort_window = (r_state != ST_IDLE) && (r_state != ST_REPORT);

    // Next-state and start-strobe decode
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.job_valid) begin
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Scanner may still be busy from a run orphaned by reset
                if (bus.sc_idle) begin
                    w_start      = 1'b1;
                    w_next_state = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!bus.sc_idle) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.sc_idle) begin
                    w_next_state = ST_DECIDE;
                end
            end
            ST_DECIDE: begin
                if (bus.sc_found || r_abort || w_runs_done || w_nonce_sum[32]) begin
                    w_next_state = ST_REPORT;
                end else begin
                    w_next_state = ST_ISSUE;
                end
            end
            ST_REPORT: begin
                if (bus.res_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State register, job registers, counters and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_blobby    <= '0;
            r_threshold <= '0;
            r_slices    <= '0;
            r_abort     <= 1'b0;
            r_result    <= '0;
        end else begin
            r_state <= w_next_state;

            // Abort only ever takes effect at the next run boundary
            if (w_abort_window && bus.abort) begin
                r_abort <= 1'b1;
            end

            if (w_counting && bus.sc_evaluating && (r_result.hashes != {64{1'b1}})) begin
                r_result.hashes <= r_result.hashes + 64'd1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (bus.job_valid) begin
                        r_blobby    <= bus.job_blobby;
                        r_threshold <= bus.job_threshold;
                        r_slices    <= (bus.job_slices == 16'd0) ? 16'd1 : bus.job_slices;
                        r_abort     <= 1'b0;
                        r_result    <= '0;
                    end
                end
                ST_ISSUE: begin
                    if (w_start) begin
                        r_result.runs <= r_result.runs + 16'd1;
                    end
                end
                ST_DECIDE: begin
                    if (bus.sc_found) begin
                        r_result.found <= 1'b1;
                        r_result.hash  <= bus.sc_hash;
                        r_result.nonce <= bus.sc_nonce;
                    end else if (r_abort) begin
                        r_result.aborted <= 1'b1;
                    end else if (!w_runs_done && !w_nonce_sum[32]) begin
                        r_blobby[NONCE_WORD] <= w_nonce_sum[31:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.job_ready    = (r_state == ST_IDLE);
    assign bus.sc_start     = w_start;
    assign bus.sc_blobby    = r_blobby;
    assign bus.sc_threshold = r_threshold;
    assign bus.res_valid    = (r_state == ST_REPORT);
    assign bus.res_found    = r_result.found;
    assign bus.res_aborted  = r_result.aborted;
    assign bus.res_hash     = r_result.hash;
    assign bus.res_nonce    = r_result.nonce;
    assign bus.res_runs     = r_result.runs;
    assign bus.res_hashes   = r_result.hashes;

endmodule
`default_nettype wire

// File: tb/tb_sha3_scan_dispatcher.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_sha3_scan_dispatcher
//  Description : Bench for sha3_scan_dispatcher with a reactive scanner
//                model and a job-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sha3_scan_dispatcher;
    import sha3_scan_pkg::*;

    localparam int IE = C_INPUT_ELEMENTS_PROPER;
    localparam int NW = 19;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sha3_scan_dispatcher_if #(.INPUT_ELEMENTS(IE)) bus ();

    sha3_scan_dispatcher #(.INPUT_ELEMENTS(IE), .NONCE_WORD(NW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic abort_scan = 1'b0;
    logic abort_host = 1'b0;
    assign bus.abort = abort_scan | abort_host;

    int n_checks = 0;
    int n_errors = 0;

    // Job plan shared with the scanner model and the monitor
    logic [IE-1:0][31:0]     g_blobby;
    logic [63:0]             g_threshold;
    logic [31:0]             g_count;
    int                      g_hit_run   = 0;
    int                      g_abort_run = 0;
    int                      g_force_len = 0;
    int                      g_job_id    = 0;
    int                      g_run_cnt   = 0;
    logic [63:0]             g_exp_hashes = '0;
    logic [31:0]             g_hit_nonce;
    logic [24:0][63:0]       g_hit_hash;

    // Expected outcome of the current job
    logic [31:0]             exp_nonce_q[$];
    logic                    exp_found   = 1'b0;
    logic                    exp_aborted = 1'b0;
    logic [15:0]             exp_runs    = '0;

    logic                    job_active = 1'b0;
    int                      n_accepts  = 0;
    int                      n_jobs     = 0;
    logic [31:0]             start_log[$];
    logic                    last_found, last_aborted;
    logic [31:0]             last_nonce;
    logic [15:0]             last_runs;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_blob(input string name, input logic [IE-1:0][31:0] act,
                              input logic [IE-1:0][31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            for (int i = 0; i < IE; i++) begin
                if (act[i] !== exp[i]) begin
                    $display("FAIL %s word %0d: got 0x%08h expected 0x%08h at %0t",
                             name, i, act[i], exp[i], $time);
                    break;
                end
            end
        end
    endtask

    task automatic check_hash(input string name, input logic [24:0][63:0] act,
                              input logic [24:0][63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            for (int i = 0; i < 25; i++) begin
                if (act[i] !== exp[i]) begin
                    $display("FAIL %s lane %0d: got 0x%016h expected 0x%016h at %0t",
                             name, i, act[i], exp[i], $time);
                    break;
                end
            end
        end
    endtask

    // Job-level reference: list of nonce windows and the final verdict
    task automatic build_model(input logic [31:0] first, input logic [15:0] slices);
        logic [32:0] sum;
        logic [31:0] n;
        int          s;
        int          r;
        s = (slices == 16'd0) ? 1 : int'(slices);
        n = first;
        r = 0;
        exp_nonce_q.delete();
        exp_found   = 1'b0;
        exp_aborted = 1'b0;
        while (1) begin
            r++;
            exp_nonce_q.push_back(n);
            if (r == g_hit_run) begin
                exp_found = 1'b1;
                break;
            end
            if (g_abort_run != 0 && r >= g_abort_run) begin
                exp_aborted = 1'b1;
                break;
            end
            if (r == s) break;
            sum = {1'b0, n} + {1'b0, g_count};
            if (sum[32]) break;
            n = sum[31:0];
        end
        exp_runs = 16'(r);
    endtask

    // Scanner model: reacts to sc_start, busy for a random number of cycles
    initial begin : scanner
        int owner;
        int idx;
        int len;
        int ackd;
        int abort_at;
        bus.sc_idle       = 1'b1;
        bus.sc_found      = 1'b0;
        bus.sc_evaluating = 1'b0;
        bus.sc_nonce      = '0;
        bus.sc_hash       = '0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.sc_start === 1'b1) begin
                owner = g_job_id;
                g_run_cnt++;
                idx      = g_run_cnt;
                len      = (g_force_len > 0) ? g_force_len : int'($urandom_range(1, 6));
                ackd     = int'($urandom_range(0, 2));
                abort_at = (idx == g_abort_run) ? int'($urandom_range(0, len - 1)) : -1;
                @(posedge clk); #1;
                bus.sc_found = 1'b0;
                repeat (ackd) begin
                    @(posedge clk); #1;
                end
                bus.sc_idle = 1'b0;
                for (int i = 0; i < len; i++) begin
                    bus.sc_evaluating = 1'($urandom_range(0, 1));
                    if (bus.sc_evaluating && owner == g_job_id) g_exp_hashes++;
                    abort_scan = (i == abort_at) && (owner == g_job_id);
                    @(posedge clk); #1;
                end
                abort_scan        = 1'b0;
                bus.sc_evaluating = 1'b0;
                if (owner == g_job_id && idx == g_hit_run) begin
                    bus.sc_nonce = g_hit_nonce;
                    bus.sc_hash  = g_hit_hash;
                    bus.sc_found = 1'b1;
                end else begin
                    bus.sc_nonce = $urandom;
                    for (int k = 0; k < 25; k++) bus.sc_hash[k] = {$urandom, $urandom};
                    bus.sc_found = 1'b0;
                end
                bus.sc_idle = 1'b1;
            end
        end
    end

    // Compare process: checks DUT outputs against the job model every cycle
    initial begin : monitor
        logic [IE-1:0][31:0] eb;
        logic [31:0]         en;
        int                  cyc;
        int                  rise_cyc;
        logic                idle_prev;
        logic                rv_prev;
        cyc = 0; rise_cyc = 0; idle_prev = 1'b1; rv_prev = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                job_active = 1'b0;
                exp_nonce_q.delete();
                rv_prev = 1'b0;
                continue;
            end
            if (bus.sc_idle && !idle_prev) rise_cyc = cyc;
            idle_prev = bus.sc_idle;

            check("job_ready", bus.job_ready, !job_active);

            if (bus.sc_start) begin
                check("start_while_busy", bus.sc_idle, 1'b1);
                if (exp_nonce_q.size() == 0) begin
                    check("sc_start_unexpected", bus.sc_start, 1'b0);
                end else begin
                    en     = exp_nonce_q.pop_front();
                    eb     = g_blobby;
                    eb[NW] = en;
                    check_blob("sc_blobby", bus.sc_blobby, eb);
                    check("sc_threshold", bus.sc_threshold, g_threshold);
                    start_log.push_back(bus.sc_blobby[NW]);
                end
            end

            if (bus.res_valid) begin
                if (!rv_prev && exp_found) check("found_latency", 64'(cyc - rise_cyc), 64'd2);
                check("res_found", bus.res_found, exp_found);
                check("res_aborted", bus.res_aborted, exp_aborted);
                check("res_runs", bus.res_runs, exp_runs);
                check("res_hashes", bus.res_hashes, g_exp_hashes);
                if (exp_found) begin
                    check("res_nonce", bus.res_nonce, g_hit_nonce);
                    check_hash("res_hash", bus.res_hash, g_hit_hash);
                end
                if (bus.res_ready) begin
                    check("runs_not_issued", 64'(exp_nonce_q.size()), 64'd0);
                    job_active   = 1'b0;
                    last_found   = bus.res_found;
                    last_aborted = bus.res_aborted;
                    last_nonce   = bus.res_nonce;
                    last_runs    = bus.res_runs;
                end
            end
            rv_prev = bus.res_valid;

            if (bus.job_valid && bus.job_ready) begin
                job_active = 1'b1;
                n_accepts++;
            end
        end
    end

    task automatic start_job(input logic [31:0] first, input logic [15:0] slices,
                             input logic [31:0] cnt, input int hit, input int ab,
                             input logic [31:0] hnonce);
        bit got;
        g_job_id++;
        g_run_cnt    = 0;
        g_exp_hashes = '0;
        g_hit_run    = hit;
        g_abort_run  = ab;
        g_count      = cnt;
        g_hit_nonce  = hnonce;
        for (int k = 0; k < 25; k++) g_hit_hash[k] = {$urandom, $urandom};
        for (int i = 0; i < IE; i++) g_blobby[i] = $urandom;
        g_blobby[NW] = first;
        g_threshold  = {$urandom, $urandom};
        build_model(first, slices);
        start_log.delete();
        @(posedge clk); #1;
        bus.job_blobby    = g_blobby;
        bus.job_threshold = g_threshold;
        bus.job_slices    = slices;
        bus.sc_scan_count = cnt;
        bus.job_valid     = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.job_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("accept_timeout", bus.job_ready, 1'b1);
        @(posedge clk); #1;
        bus.job_valid = 1'b0;
        n_jobs++;
    endtask

    task automatic finish_job(input int bp, input bit hold_valid);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (bus.res_valid) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            check("res_valid_timeout", bus.res_valid, 1'b1);
            rst_n = 1'b0;
            @(posedge clk); @(posedge clk); #1;
            rst_n = 1'b1;
        end else begin
            repeat (bp) begin
                @(posedge clk); #1;
                bus.job_valid = hold_valid;
                abort_host    = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            abort_host    = 1'b0;
            bus.job_valid = 1'b0;
            bus.res_ready = 1'b1;
            @(posedge clk); #1;
            bus.res_ready = 1'b0;
        end
    endtask

    task automatic run_job(input logic [31:0] first, input logic [15:0] slices,
                           input logic [31:0] cnt, input int hit, input int ab,
                           input logic [31:0] hnonce, input int bp, input bit hold_valid);
        start_job(first, slices, cnt, hit, ab, hnonce);
        finish_job(bp, hold_valid);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_job_ready"},    bus.job_ready, 1'b1);
        check({tag, "_sc_start"},     bus.sc_start, 1'b0);
        check({tag, "_res_valid"},    bus.res_valid, 1'b0);
        check({tag, "_sc_threshold"}, bus.sc_threshold, 64'd0);
        check_blob({tag, "_sc_blobby"}, bus.sc_blobby, '0);
        check({tag, "_res_found"},    bus.res_found, 1'b0);
        check({tag, "_res_aborted"},  bus.res_aborted, 1'b0);
        check({tag, "_res_nonce"},    bus.res_nonce, 32'd0);
        check({tag, "_res_runs"},     bus.res_runs, 16'd0);
        check({tag, "_res_hashes"},   bus.res_hashes, 64'd0);
        check_hash({tag, "_res_hash"}, bus.res_hash, '0);
    endtask

    initial begin : watchdog
        #2_000_000;
        n_errors++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] first;
        logic [31:0] cnt;
        logic [15:0] slices;
        int          hit;
        int          ab;
        bit          got;

        bus.job_valid     = 1'b0;
        bus.job_blobby    = '0;
        bus.job_threshold = '0;
        bus.job_slices    = '0;
        bus.sc_scan_count = '0;
        bus.res_ready     = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Single-run hit
        run_job($urandom, 16'd1, 32'h100, 1, 0, 32'h1234, 0, 1'b0);
        check("hit_found", last_found, 1'b1);
        check("hit_nonce", last_nonce, 32'h1234);
        check("hit_runs", last_runs, 16'd1);

        // Multi-run miss walks the nonce window
        run_job(32'h10, 16'd3, 32'h100, 0, 0, 32'h0, 0, 1'b0);
        check("multi_start_count", 64'(start_log.size()), 64'd3);
        if (start_log.size() == 3) begin
            check("multi_nonce0", start_log[0], 32'h10);
            check("multi_nonce1", start_log[1], 32'h110);
            check("multi_nonce2", start_log[2], 32'h210);
        end
        check("multi_found", last_found, 1'b0);
        check("multi_runs", last_runs, 16'd3);

        // Nonce carry-out ends the job early
        run_job(32'hFFFF_FF80, 16'd5, 32'h100, 0, 0, 32'h0, 0, 1'b0);
        check("wrap_found", last_found, 1'b0);
        check("wrap_aborted", last_aborted, 1'b0);
        check("wrap_runs", last_runs, 16'd1);

        // Abort during run 2 of 4
        run_job(32'h1000, 16'd4, 32'h80, 0, 2, 32'h0, 0, 1'b0);
        check("abort_aborted", last_aborted, 1'b1);
        check("abort_found", last_found, 1'b0);
        check("abort_runs", last_runs, 16'd2);

        // Zero slices behaves as one
        run_job(32'h40, 16'd0, 32'h100, 0, 0, 32'h0, 0, 1'b0);
        check("zero_slices_runs", last_runs, 16'd1);

        // Backpressure with a competing job offer
        run_job(32'h2000, 16'd2, 32'h10, 2, 0, 32'hCAFE_0001, 10, 1'b1);
        check("bp_accepts", 64'(n_accepts), 64'(n_jobs));
        check("bp_nonce", last_nonce, 32'hCAFE_0001);

        // Reset in the middle of a long run
        g_force_len = 20;
        start_job(32'h100, 16'd3, 32'h40, 0, 0, 32'h0);
        got = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (!bus.sc_idle) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("reset_run_timeout", bus.sc_idle, 1'b0);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrun_reset");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        g_force_len = 0;
        run_job(32'h5000, 16'd2, 32'h20, 0, 0, 32'h0, 0, 1'b0);
        check("after_reset_runs", last_runs, 16'd2);
        check("after_reset_found", last_found, 1'b0);

        // Randomized jobs
        for (int j = 0; j < 40; j++) begin
            slices = 16'($urandom_range(0, 5));
            cnt    = ($urandom_range(0, 3) == 0) ? (32'h4000_0000 + $urandom_range(0, 32'hFFFF))
                                                 : 32'($urandom_range(1, 32'h1000));
            first  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_F000 + $urandom_range(0, 32'hFFF))
                                                 : $urandom;
            hit    = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : 0;
            ab     = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            run_job(first, slices, cnt, hit, ab, $urandom,
                    int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
        end
        check("total_accepts", 64'(n_accepts), 64'(n_jobs));

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
